riscv_hazard_scoreboard: RTL and testbench

//  Parametrised successor to the fixed 5-stage forwarding/hazard pair. It tracks each in-flight

---
 rtl/riscv_pipe_pkg.sv | 15 +
 rtl/hzd_src_match.sv | 31 +++
 rtl/riscv_hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_riscv_hazard_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard: the in-flight entry record and
// the register/forward-select constants.
package riscv_pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  localparam int         FWD_RF = 0;
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hzd_src_match.sv
// Youngest-match priority encoder for one source operand: picks the forwarding stage
// and flags a load result that is not yet available.
module hzd_src_match
  import riscv_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2,
  parameter int FW         = $clog2(PIPE_DEPTH + 1)
) (
  input  sb_entry_t [PIPE_DEPTH:1] stages_i,
  input  logic [4:0]               src_i,
  input  logic                     used_i,
  output logic [FW-1:0]            sel_o,
  output logic                     unready_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel_o     = FW'(FWD_RF);
    unready_o = 1'b0;
    // Walk oldest to youngest so the lowest matching stage is written last and wins.
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (used_i && (src_i != REG_X0) && stages_i[k].valid && stages_i[k].wr &&
          (stages_i[k].rd == src_i)) begin
        sel_o     = FW'(k);
        unready_o = stages_i[k].ld && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Parametrised forwarding / load-use hazard scoreboard between decode and execute.
// Optional performance counters are built only when HZD_PERF_CNT_EN is defined.
module riscv_hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH   = 3,
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int FW           = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic                  issue_rs1_used_i,
  input  logic                  issue_rs2_used_i,
  input  logic [4:0]            issue_rd_i,
  input  logic                  issue_regwrite_i,
  input  logic                  issue_memread_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  issue_fire_o,
  output logic [FW-1:0]         fwd_a_o,
  output logic [FW-1:0]         fwd_b_o,
  output logic [PIPE_DEPTH-1:0] inflight_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
);

  if (LOAD_LAT < 1 || LOAD_LAT > PIPE_DEPTH) begin : g_bad_load_lat
    $error("riscv_hazard_scoreboard: LOAD_LAT must be within 1..PIPE_DEPTH");
  end
  if (FLUSH_STAGES < 0 || FLUSH_STAGES >= PIPE_DEPTH) begin : g_bad_flush_stages
    $error("riscv_hazard_scoreboard: FLUSH_STAGES must be within 0..PIPE_DEPTH-1");
  end

  sb_entry_t [PIPE_DEPTH:1] stages_q, stages_d;
  sb_entry_t                issue_entry;
  logic                     unready_a, unready_b;

  hzd_src_match #(.PIPE_DEPTH(PIPE_DEPTH), .LOAD_LAT(LOAD_LAT), .FW(FW)) u_match_a (
    .stages_i  (stages_q),
    .src_i     (issue_rs1_i),
    .used_i    (issue_rs1_used_i),
    .sel_o     (fwd_a_o),
    .unready_o (unready_a)
  );

  hzd_src_match #(.PIPE_DEPTH(PIPE_DEPTH), .LOAD_LAT(LOAD_LAT), .FW(FW)) u_match_b (
    .stages_i  (stages_q),
    .src_i     (issue_rs2_i),
    .used_i    (issue_rs2_used_i),
    .sel_o     (fwd_b_o),
    .unready_o (unready_b)
  );

  // Flush overrides stall: a redirected instruction never waits on its operands.
  assign stall_o      = issue_valid_i && !flush_i && (unready_a || unready_b);
  assign issue_fire_o = issue_valid_i && !stall_o && !flush_i;

  always_comb begin
    issue_entry.valid = 1'b1;
    issue_entry.rd    = issue_rd_i;
    issue_entry.wr    = issue_regwrite_i && (issue_rd_i != REG_X0);
    issue_entry.ld    = issue_memread_i;
  end

  // A flush kills the wrong-path entries in the youngest FLUSH_STAGES stages as they shift.
  always_comb begin
    stages_d    = '0;
    stages_d[1] = issue_fire_o ? issue_entry : '0;
    for (int k = 2; k <= PIPE_DEPTH; k++) begin
      stages_d[k] = (flush_i && (k - 1 <= FLUSH_STAGES)) ? '0 : stages_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_ni) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  always_comb begin
    inflight_o = '0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      inflight_o[k-1] = stages_q[k].valid;
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard (PIPE_DEPTH=3, LOAD_LAT=2, FLUSH_STAGES=1):
// a per-cycle vector table plus hand-written reset sequences.
module tb_riscv_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        iv;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, rw, mr, fl;
  logic        stall, fire;
  logic [1:0]  fwd_a, fwd_b;
  logic [2:0]  inflight;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  riscv_hazard_scoreboard #(.PIPE_DEPTH(3), .LOAD_LAT(2), .FLUSH_STAGES(1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (iv),
    .issue_rs1_i      (rs1),
    .issue_rs2_i      (rs2),
    .issue_rs1_used_i (u1),
    .issue_rs2_used_i (u2),
    .issue_rd_i       (rd),
    .issue_regwrite_i (rw),
    .issue_memread_i  (mr),
    .flush_i          (fl),
    .stall_o          (stall),
    .issue_fire_o     (fire),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b),
    .inflight_o       (inflight),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic       e_stall, e_fire;
    logic [1:0] e_fa, e_fb;
    logic [2:0] e_inf;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic ua,
                              input logic [4:0] b, input logic ub, input logic [4:0] d,
                              input logic w, input logic m, input logic f,
                              input logic es, input logic ef, input logic [1:0] efa,
                              input logic [1:0] efb, input logic [2:0] ei);
    vec_t r;
    r.iv = v; r.rs1 = a; r.u1 = ua; r.rs2 = b; r.u2 = ub; r.rd = d;
    r.rw = w; r.mr = m; r.fl = f;
    r.e_stall = es; r.e_fire = ef; r.e_fa = efa; r.e_fb = efb; r.e_inf = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iv = v.iv; rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2;
    rd = v.rd; rw = v.rw; mr = v.mr; fl = v.fl;
  endtask

  vec_t vecs[$];
  vec_t idle;
  int   exp_stalls;
  int   exp_flushes;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    //             iv rs1 u1 rs2 u2 rd rw mr fl  stall fire fa fb inflight
    vecs.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0,  0, 1, 0, 0, 3'b000)); // add x5
    vecs.push_back(mk(1,  5, 1,  0, 0, 10, 1, 0, 0,  0, 1, 1, 0, 3'b001)); // rs1=x5 @k1
    vecs.push_back(mk(1,  3, 1,  5, 1, 11, 1, 0, 0,  0, 1, 0, 2, 3'b011)); // rs2=x5 @k2
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 3'b111));
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 3'b110));
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 3'b100));
    vecs.push_back(mk(1,  1, 1,  0, 0,  7, 1, 1, 0,  0, 1, 0, 0, 3'b000)); // lw x7
    vecs.push_back(mk(1,  7, 1,  0, 0, 12, 1, 0, 0,  1, 0, 1, 0, 3'b001)); // load-use stall
    vecs.push_back(mk(1,  7, 1,  0, 0, 12, 1, 0, 0,  0, 1, 2, 0, 3'b010)); // load fwd @k2
    vecs.push_back(mk(1,  1, 1,  0, 0,  0, 1, 0, 0,  0, 1, 0, 0, 3'b101)); // addi x0
    vecs.push_back(mk(1,  0, 1, 12, 1,  6, 1, 0, 0,  0, 1, 0, 2, 3'b011)); // x0 never fwd
    vecs.push_back(mk(1,  2, 1,  0, 0, 13, 1, 0, 0,  0, 1, 0, 0, 3'b111));
    vecs.push_back(mk(1,  0, 0,  0, 0,  6, 1, 0, 0,  0, 1, 0, 0, 3'b111)); // second x6
    vecs.push_back(mk(1,  6, 1,  6, 1,  0, 0, 0, 0,  0, 1, 1, 1, 3'b111)); // youngest x6
    vecs.push_back(mk(1, 13, 1, 13, 0,  0, 0, 0, 0,  0, 1, 3, 0, 3'b111)); // k3, rs2 unused
    vecs.push_back(mk(1,  1, 1,  0, 0,  9, 1, 0, 0,  0, 1, 0, 0, 3'b111)); // x9 writer
    vecs.push_back(mk(1,  9, 1,  0, 0, 14, 1, 0, 1,  0, 0, 1, 0, 3'b111)); // flush
    vecs.push_back(mk(1,  9, 1,  0, 0, 15, 1, 0, 0,  0, 1, 0, 0, 3'b100)); // x9 killed
    vecs.push_back(mk(1,  0, 0,  0, 0,  8, 1, 1, 0,  0, 1, 0, 0, 3'b001)); // lw x8
    vecs.push_back(mk(1,  8, 1,  0, 0,  0, 0, 0, 1,  0, 0, 1, 0, 3'b011)); // flush beats stall
    vecs.push_back(mk(1,  8, 1,  0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 3'b100)); // lw x8 killed
    vecs.push_back(mk(1,  0, 0,  0, 0, 20, 1, 1, 0,  0, 1, 0, 0, 3'b001)); // lw x20
    vecs.push_back(mk(1,  0, 0, 20, 1, 21, 1, 0, 0,  1, 0, 0, 1, 3'b011)); // rs2 load-use
    vecs.push_back(mk(1,  0, 0, 20, 1, 21, 1, 0, 0,  0, 1, 0, 2, 3'b110));

    // Power-on reset
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", stall, 0);
    check("reset inflight", inflight, 0);
    check("reset stall_cnt", stall_cnt, 0);
    check("reset flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One load-use pair, then reset in the middle of a second stall
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pair1 stall", stall, 1);
    @(negedge clk);
    #1;
    check("pair1 released", stall, 0);
    check("pair1 fwd_a", fwd_a, 2);
`ifdef HZD_PERF_CNT_EN
    check("pair1 stall_cnt", stall_cnt, 1);
`else
    check("pair1 stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pair2 stall", stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst stall", stall, 0);
    check("midrst fire", fire, 1);
    check("midrst fwd_a", fwd_a, 0);
    check("midrst inflight", inflight, 0);
    check("midrst stall_cnt", stall_cnt, 0);
    check("midrst flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release stall", stall, 0);
    check("release fwd_a", fwd_a, 0);
    check("release fwd_b", fwd_b, 0);
    check("release inflight", inflight, 0);
    drive(idle);
    repeat (3) @(negedge clk);

    // Vector table, one row per cycle
    exp_stalls  = 0;
    exp_flushes = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("row%0d stall", i), stall, vecs[i].e_stall);
      check($sformatf("row%0d fire", i), fire, vecs[i].e_fire);
      check($sformatf("row%0d fwd_a", i), fwd_a, vecs[i].e_fa);
      check($sformatf("row%0d fwd_b", i), fwd_b, vecs[i].e_fb);
      check($sformatf("row%0d inflight", i), inflight, vecs[i].e_inf);
      if (vecs[i].e_stall) exp_stalls++;
      if (vecs[i].fl) exp_flushes++;
    end
    @(negedge clk);
    drive(idle);
    #1;
`ifdef HZD_PERF_CNT_EN
    check("final stall_cnt", stall_cnt, exp_stalls);
    check("final flush_cnt", flush_cnt, exp_flushes);
`else
    check("final stall_cnt", stall_cnt, 0);
    check("final flush_cnt", flush_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
